// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (LSB first); optional signed-overflow flag under SERIAL_SUB_OVF_EN.
// Latency WIDTH+1 cycles from start accept to done_o; start_i is ignored while busy_o is high.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] D_o,
  output logic             Bo_o
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             bw;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             bw_nxt;
  logic [WIDTH-1:0] res_nxt;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;
`endif

  // Full-width shift keeps the WIDTH=1 case free of empty part-selects.
  always_comb begin
    d       = a_sr[0] ^ b_sr[0] ^ bw;
    bw_nxt  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bw);
    res_nxt = (res_sr >> 1) | (WIDTH'(d) << (WIDTH - 1));
  end

  assign busy_o = (state != IDLE);
  assign done_o = (state == DONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      bw     <= 1'b0;
      cnt    <= '0;
      D_o    <= '0;
      Bo_o   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf_o  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            a_sr   <= A_i;
            b_sr   <= B_i;
            res_sr <= '0;
            bw     <= 1'b0;
            cnt    <= '0;
            state  <= RUN;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= A_i[WIDTH-1];
            b_msb  <= B_i[WIDTH-1];
`endif
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_nxt;
          bw     <= bw_nxt;
          cnt    <= cnt + 1'b1;
          // Last bit lands straight in the outputs so they never show a partial result.
          if (cnt == LAST) begin
            state <= DONE;
            D_o   <= res_nxt;
            Bo_o  <= bw_nxt;
`ifdef SERIAL_SUB_OVF_EN
            ovf_o <= (a_msb != b_msb) && (d != a_msb);
`endif
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; legal range is 1..32.
REQ-002 The module SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have port start_i, input, 1 bit: request to begin a subtraction; sampled only in IDLE.
REQ-005 The module SHALL have port A_i, input, WIDTH bits: minuend; captured when start_i is accepted.
REQ-006 The module SHALL have port B_i, input, WIDTH bits: subtrahend; captured when start_i is accepted.
REQ-007 The module SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.
REQ-008 The module SHALL have port done_o, output, 1 bit: one-cycle pulse marking a valid result.
REQ-009 The module SHALL have port D_o, output, WIDTH bits: difference A_i-B_i modulo 2^WIDTH.
REQ-010 The module SHALL have port Bo_o, output, 1 bit: borrow out, high when A_i < B_i (unsigned).

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 In IDLE with start_i=1, the next edge SHALL capture A_i and B_i into shift registers, clear the borrow flop and the bit counter, and enter RUN.
REQ-013 Each RUN edge SHALL compute d=a0^b0^bw and bw_next=(~a0&b0)|(~(a0^b0)&bw) on the operand LSBs, shift both operands right, and shift d into the result register MSB.
REQ-014 RUN SHALL last exactly WIDTH edges; on the WIDTH-th edge the state SHALL become DONE, and D_o and Bo_o SHALL load the completed result and final borrow.
REQ-015 In DONE, done_o SHALL be 1 for exactly one cycle, and the next edge SHALL return the state to IDLE.
REQ-016 If start is accepted at edge k, done_o SHALL be high in the cycle after edge k+WIDTH, giving a latency of WIDTH+1 cycles.
REQ-017 D_o and Bo_o SHALL hold their last values until the next DONE, and SHALL NOT change during RUN.
REQ-018 start_i SHALL be ignored in RUN and DONE, so a new start is earliest accepted in the IDLE cycle after done_o.
REQ-019 Operand inputs SHALL be don't-care except on the start-accept edge.
REQ-020 For WIDTH=1, RUN SHALL last one edge and the same rules SHALL apply.

Reset
REQ-021 While rst_i=1, the state SHALL be IDLE, and busy_o, done_o, D_o, Bo_o, the borrow flop, the counter and the operand registers SHALL be 0, regardless of the clock.
REQ-022 Reset asserted mid-RUN SHALL abort the operation with no done_o pulse, and the first start after reset release SHALL be handled normally.

Configuration
REQ-023 When macro SERIAL_SUB_OVF_EN is defined, the module SHALL add output ovf_o, 1 bit, reset 0, loaded with D_o at DONE and holding the two's-complement signed overflow (A_msb!=B_msb)&&(D_msb!=A_msb).
REQ-024 When SERIAL_SUB_OVF_EN is undefined, port ovf_o and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-025 The bench SHALL check: A=0x05, B=0x03, start -> done_o in the 9th cycle after the accept edge, D_o=0x02, Bo_o=0, ovf_o=0.
REQ-026 The bench SHALL check: A=0x03, B=0x05 -> D_o=0xFE, Bo_o=1, ovf_o=0; A=0x00, B=0x00 -> D_o=0x00, Bo_o=0.
REQ-027 The bench SHALL check: A=0x80, B=0x01 -> D_o=0x7F, Bo_o=0, ovf_o=1 (macro on); ovf_o port absent (macro off).
REQ-028 The bench SHALL check: start_i held high continuously with A=0xFF, B=0x01 -> done_o pulses every 10 cycles, D_o=0xFE each time, and operand changes during RUN have no effect.
REQ-029 The bench SHALL check: rst_i pulsed at the 4th RUN cycle -> all outputs 0 immediately, no done_o pulse, and a subsequent A=0x10, B=0x20 -> D_o=0xF0, Bo_o=1.
REQ-030 The bench SHALL check: 1000 random operand pairs -> D_o==(A-B)&0xFF and Bo_o==(A<B) each run, and busy_o high from the accept edge through the done_o cycle.
